pixel_quad_store: RTL
=====================

// Module: pixel_quad_store
// PURPOSE
//   Digital in-pixel memory for one 2x2 pixel quad: the pixel-side end of the ramp/readout bus.
//   During convert, each pixel captures the shared digital ramp code on its comparator's first trip.
//   During read phases, it drives the stored codes back onto the four pixel data buses.
//   Sits between the per-pixel comparators and the column readout, driven by the pixel sequencer.
// PARAMETERS
//   DATA_W    8     width of ramp code and stored pixel value
//   CODE_MAX  255   value stored for a pixel that never trips during convert (overflow code)
// PORTS
//   clk        in   1          clock
//   reset      in   1          reset, asynchronous, active-high
//   erase      in   1          sequencer erase phase; clears quad memory
//   convert    in   1          sequencer convert phase; ramp running
//   read1      in   1          readout phase 1: pixels 0 and 2 onto bus1 and bus3
//   read2      in   1          readout phase 2: pixels 1 and 3 onto bus2 and bus4
//   ramp_code  in   DATA_W     digital ramp value, valid while convert=1
//   cmp_trip   in   4          per-pixel comparator output (1 = ramp >= pixel voltage)
//   bus1..bus4 out  DATA_W     per-bus drive data; 0 when not enabled
//   bus_oe     out  4          per-bus output enable (bit k-1 enables busk)
//   latched    out  4          pixel captured a code during the current/last convert
//   overflow   out  4          pixel never tripped; stored CODE_MAX
//   proto_err  out  1          one-cycle pulse on an illegal phase combination
// BEHAVIOUR
//   Reset: all mem[i]=0, latched=0, overflow=0, proto_err=0, state=IDLE, bus_oe=0, bus1..4=0.
//   States: IDLE -> CONV when convert=1 and erase=0.
//           CONV -> HOLD when convert falls.
//           HOLD -> CONV when convert=1 (new frame; auto-clears latched, overflow and mem as on entry).
//           Any state -> IDLE when erase=1.
//   IDLE/erase: each cycle with erase=1, mem=0, latched=0 and overflow=0. Erase takes priority over all other inputs.
//   Entry to CONV (first posedge with convert=1): clear mem, latched and overflow.
//   The trip sample is also taken on this same edge.
//   CONV: at each posedge with convert=1, for each i with latched[i]=0 and cmp_trip[i]=1:
//     mem[i] <= ramp_code and latched[i] <= 1 (first trip wins).
//     Later trips and a deasserting cmp_trip are ignored until the next convert.
//   Convert falling (first posedge in CONV with convert=0): each i with latched[i]=0 gets mem[i] <= CODE_MAX, overflow[i] <= 1.
//     State becomes HOLD.
//   Ramp code is captured as-is with no arithmetic; a ramp wrap is the sequencer's problem and is not detected here.
//   Read drive is combinational, so data is valid in the same cycle read is asserted; consumers sample on the posedge:
//     read1=1, read2=0, not CONV: bus_oe=4'b0101, bus1=mem[0], bus3=mem[2].
//     read2=1, read1=0, not CONV: bus_oe=4'b1010, bus2=mem[1], bus4=mem[3].
//     Every non-enabled bus output is 0.
//   Illegal combinations -> proto_err=1 for the cycle (registered, 1-cycle latency):
//     read1 & read2: read1 wins and read2 is ignored.
//     read1|read2 while state=CONV or convert=1: no bus enabled.
//     convert & erase: erase wins.
//   Reads in IDLE are legal and drive the erased value 0.
//   A read in HOLD is non-destructive; repeated reads return identical data.
//   Reset mid-operation: immediate return to IDLE with all memory cleared, no overflow fill.
// TESTING
//   1. Reset: assert reset mid-CONV -> bus_oe=0, latched=0, mem reads 0 after release.
//   2. Capture: erase 5 cycles, convert 255 cycles with ramp_code=cycle index; trip pixels at codes 10/64/128/200.
//      -> read1 gives bus1=10, bus3=128; read2 gives bus2=64, bus4=200.
//   3. First-trip-wins: pixel0 trips at 30, untrips at 31, re-trips at 90 -> mem[0]=30, latched[0]=1.
//   4. Overflow: pixel3 never trips -> overflow=4'b1000, read2 gives bus4=255, and CODE_MAX=100 build gives 100.
//   5. Protocol: read1&read2 together -> proto_err pulse, bus_oe=4'b0101.
//      read1 during convert -> bus_oe=0, proto_err=1.
//   6. Frame restart: a second convert after HOLD clears the prior codes; new trips at 5/6/7/8 read back exactly.
//      Erase during CONV -> IDLE and all reads return 0.

Source files
------------

// File: rtl/pixel_quad_store.sv
// pixel_quad_store: in-pixel digital memory for one 2x2 pixel quad.
// Convert captures the shared ramp code on each comparator's first trip;
// pixels that never trip are filled with CODE_MAX when convert falls.
// Read phases drive the stored codes onto the four pixel data buses.
//
// Bus handshake: read1/read2 act as the request, bus_oe is the response
// valid. Data on busN is valid in the same cycle bus_oe[N-1] is high and is
// sampled by the column readout on the next posedge; there is no backpressure.
module pixel_quad_store #(
  parameter int          DATA_W   = 8,
  parameter int unsigned CODE_MAX = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              erase,
  input  logic              convert,
  input  logic              read1,
  input  logic              read2,
  input  logic [DATA_W-1:0] ramp_code,
  input  logic [3:0]        cmp_trip,
  output logic [DATA_W-1:0] bus1,
  output logic [DATA_W-1:0] bus2,
  output logic [DATA_W-1:0] bus3,
  output logic [DATA_W-1:0] bus4,
  output logic [3:0]        bus_oe,
  output logic [3:0]        latched,
  output logic [3:0]        overflow,
  output logic              proto_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] CODE_MAX_W = DATA_W'(CODE_MAX);

  state_t                  state_q, state_d;
  logic [3:0][DATA_W-1:0]  mem_q, mem_d;
  logic [3:0]              latched_q, latched_d;
  logic [3:0]              overflow_q, overflow_d;
  logic                    proto_err_q, proto_err_d;

  logic rd_ok;
  logic en1;
  logic en2;

  // Next-state, capture and overflow-fill logic; erase overrides everything.
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    latched_d  = latched_q;
    overflow_d = overflow_q;

    // Illegal phase combinations, reported one cycle later.
    proto_err_d = (read1 & read2)
                | ((read1 | read2) & ((state_q == ST_CONV) | convert))
                | (convert & erase);

    if (erase) begin
      state_d    = ST_IDLE;
      mem_d      = '0;
      latched_d  = '0;
      overflow_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (convert) begin
            // New frame: clear the quad and take the first trip sample now.
            state_d    = ST_CONV;
            overflow_d = '0;
            latched_d  = cmp_trip;
            for (int i = 0; i < 4; i++) begin
              mem_d[i] = cmp_trip[i] ? ramp_code : '0;
            end
          end
        end
        ST_CONV: begin
          if (convert) begin
            // First trip wins; later trips and untrips are ignored.
            for (int i = 0; i < 4; i++) begin
              if (!latched_q[i] && cmp_trip[i]) begin
                mem_d[i]     = ramp_code;
                latched_d[i] = 1'b1;
              end
            end
          end else begin
            // Ramp finished: pixels that never tripped get the overflow code.
            state_d = ST_HOLD;
            for (int i = 0; i < 4; i++) begin
              if (!latched_q[i]) begin
                mem_d[i]      = CODE_MAX_W;
                overflow_d[i] = 1'b1;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, memory and status registers; asynchronous reset clears the quad.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_q       <= '0;
      latched_q   <= '0;
      overflow_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      latched_q   <= latched_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Combinational read drive; read1 wins over read2, nothing drives during convert.
  always_comb begin
    rd_ok  = (state_q != ST_CONV) && !convert;
    en1    = read1 && rd_ok;
    en2    = read2 && !read1 && rd_ok;
    bus_oe = {en2, en1, en2, en1};
    bus1   = en1 ? mem_q[0] : '0;
    bus3   = en1 ? mem_q[2] : '0;
    bus2   = en2 ? mem_q[1] : '0;
    bus4   = en2 ? mem_q[3] : '0;
  end

  assign latched   = latched_q;
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;
  assign dbg_state = state_q;

endmodule
